reg_irq_control: RTL and testbench

Parametrised successor of the fixed 5-bit control / 8-bit mask register block. It holds four memory-mapped registers: interrupt pending, control, interrupt mask and status. It adds synchronised rising-edge interrupt capture, sticky write-1-to-clear pending bits, self-clearing pulse control bits, a registered read port and a masked, registered irq output. It sits between the bus-slave decode logic and the robot/video datapath control lines.

---
 rtl/reg_irq_pkg.sv | 20 ++
 rtl/reg_irq_control_if.sv | 31 +++
 rtl/reg_irq_control_edge_sync.sv | 36 +++
 rtl/reg_irq_control.sv | 151 +++++++++++++++
 tb/tb_reg_irq_control.sv | 317 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/reg_irq_pkg.sv
// Shared definitions for the interrupt/control register block.
// Holds the register address map, the address type used on the
// register bus and the default width constants for the block parameters.
package reg_irq_pkg;

  typedef logic [1:0] reg_addr_t;

  localparam reg_addr_t ADDR_PENDING = 2'd0;
  localparam reg_addr_t ADDR_CONTROL = 2'd1;
  localparam reg_addr_t ADDR_MASK    = 2'd2;
  localparam reg_addr_t ADDR_STATUS  = 2'd3;

  localparam int DEF_DATA_REG_BITS = 32;
  localparam int DEF_CTRL_BITS     = 5;
  localparam int DEF_PULSE_BITS    = 3;
  localparam int DEF_STATUS_BITS   = 6;
  localparam int DEF_NUM_IRQ       = 8;
  localparam int DEF_SYNC_STAGES   = 2;

endpackage

// File: rtl/reg_irq_control_if.sv
// Register bus between the bus-slave decode logic (master) and the
// register block (slave).
//   address  : register select
//   wr / rd  : single-cycle write / read strobes
//   wr_data  : write data
//   rd_data  : registered read data (holds when rd_valid is low)
//   rd_valid : one-cycle pulse marking rd_data as fresh
interface reg_irq_control_if
  import reg_irq_pkg::*;
#(
  parameter int DATA_REG_BITS = DEF_DATA_REG_BITS
) ();

  reg_addr_t                address;
  logic                     wr;
  logic                     rd;
  logic [DATA_REG_BITS-1:0] wr_data;
  logic [DATA_REG_BITS-1:0] rd_data;
  logic                     rd_valid;

  modport master (
    output address, wr, rd, wr_data,
    input  rd_data, rd_valid
  );

  modport slave (
    input  address, wr, rd, wr_data,
    output rd_data, rd_valid
  );

endinterface

// File: rtl/reg_irq_control_edge_sync.sv
// Synchroniser plus rising-edge detector for asynchronous level sources.
//   clk, rst : system clock, asynchronous active-high reset
//   async_in : asynchronous level inputs
//   rise_out : one-cycle pulse per synchronised 0->1 transition
// The history flop is cleared by reset, so a source that is already high
// when reset releases is reported as a fresh edge once synchronised.
module irq_edge_sync
  import reg_irq_pkg::*;
#(
  parameter int WIDTH  = DEF_NUM_IRQ,
  parameter int STAGES = DEF_SYNC_STAGES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] rise_out
);

  // Stage 0 is the metastability-catching flop; stage STAGES-1 is the clean one.
  logic [STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]             hist_r;

  // Synchroniser shift chain and edge-history flop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {(STAGES*WIDTH){1'b0}};
      hist_r <= {WIDTH{1'b0}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], async_in};
      hist_r <= sync_r[STAGES-1];
    end
  end

  assign rise_out = sync_r[STAGES-1] & ~hist_r;

endmodule

// File: rtl/reg_irq_control.sv
// Four-register interrupt / control block.
//   clk, rst   : system clock, asynchronous active-high reset
//   bus        : register bus (slave side): address, wr, rd, wr_data,
//                rd_data (registered), rd_valid (one-cycle pulse)
//   irq_src    : asynchronous level interrupt sources
//   ext_status : external status, readable at STATUS
//   ctrl_out   : persistent control bits
//   ctrl_pulse : one-cycle command pulses written through CONTROL
//   irq        : registered |(pending & mask)
// Registers: 0 PENDING (W1C), 1 CONTROL, 2 MASK, 3 STATUS (read-only).
module reg_irq_control
  import reg_irq_pkg::*;
#(
  parameter int DATA_REG_BITS = DEF_DATA_REG_BITS,
  parameter int CTRL_BITS     = DEF_CTRL_BITS,
  parameter int PULSE_BITS    = DEF_PULSE_BITS,
  parameter int STATUS_BITS   = DEF_STATUS_BITS,
  parameter int NUM_IRQ       = DEF_NUM_IRQ,
  parameter int SYNC_STAGES   = DEF_SYNC_STAGES
) (
  input  logic                   clk,
  input  logic                   rst,
  reg_irq_control_if.slave       bus,
  input  logic [NUM_IRQ-1:0]     irq_src,
  input  logic [STATUS_BITS-1:0] ext_status,
  output logic [CTRL_BITS-1:0]   ctrl_out,
  output logic [PULSE_BITS-1:0]  ctrl_pulse,
  output logic                   irq
);

  if (CTRL_BITS + PULSE_BITS > DATA_REG_BITS) begin : g_bad_ctrl_width
    $error("CTRL_BITS+PULSE_BITS exceeds DATA_REG_BITS");
  end
  if (STATUS_BITS + CTRL_BITS > DATA_REG_BITS) begin : g_bad_status_width
    $error("STATUS_BITS+CTRL_BITS exceeds DATA_REG_BITS");
  end
  if (NUM_IRQ > DATA_REG_BITS) begin : g_bad_irq_width
    $error("NUM_IRQ exceeds DATA_REG_BITS");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_depth
    $error("SYNC_STAGES must be at least 2");
  end

  logic [NUM_IRQ-1:0]       rise_s;
  logic [NUM_IRQ-1:0]       clear_s;
  logic [NUM_IRQ-1:0]       pending_r;
  logic [NUM_IRQ-1:0]       mask_r;
  logic [CTRL_BITS-1:0]     ctrl_r;
  logic [PULSE_BITS-1:0]    pulse_r;
  logic [DATA_REG_BITS-1:0] rd_mux_s;
  logic [DATA_REG_BITS-1:0] rd_data_r;
  logic                     rd_valid_r;
  logic                     irq_r;
  logic                     wr_pending_s;
  logic                     wr_control_s;
  logic                     wr_mask_s;
  logic                     unused_s;

  irq_edge_sync #(
    .WIDTH  (NUM_IRQ),
    .STAGES (SYNC_STAGES)
  ) u_edge_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (irq_src),
    .rise_out (rise_s)
  );

  // Write decode; STATUS is read-only so a write there selects nothing
  always_comb begin
    wr_pending_s = 1'b0;
    wr_control_s = 1'b0;
    wr_mask_s    = 1'b0;
    if (bus.wr) begin
      case (bus.address)
        ADDR_PENDING: wr_pending_s = 1'b1;
        ADDR_CONTROL: wr_control_s = 1'b1;
        ADDR_MASK:    wr_mask_s    = 1'b1;
        default:      wr_mask_s    = 1'b0;
      endcase
    end else begin
      wr_pending_s = 1'b0;
    end
  end

  assign clear_s = wr_pending_s ? bus.wr_data[NUM_IRQ-1:0] : {NUM_IRQ{1'b0}};

  // Read mux: fields zero-extended, pulse bits never read back
  always_comb begin
    rd_mux_s = {DATA_REG_BITS{1'b0}};
    case (bus.address)
      ADDR_PENDING: rd_mux_s[NUM_IRQ-1:0]   = pending_r;
      ADDR_CONTROL: rd_mux_s[CTRL_BITS-1:0] = ctrl_r;
      ADDR_MASK:    rd_mux_s[NUM_IRQ-1:0]   = mask_r;
      ADDR_STATUS:  rd_mux_s[STATUS_BITS+CTRL_BITS-1:0] = {ext_status, ctrl_r};
      default:      rd_mux_s = {DATA_REG_BITS{1'b0}};
    endcase
  end

  // Control and mask registers; pulse bits live for exactly one cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctrl_r  <= {CTRL_BITS{1'b0}};
      pulse_r <= {PULSE_BITS{1'b0}};
      mask_r  <= {NUM_IRQ{1'b0}};
    end else begin
      if (wr_control_s) begin
        ctrl_r <= bus.wr_data[CTRL_BITS-1:0];
      end
      pulse_r <= wr_control_s ? bus.wr_data[CTRL_BITS+PULSE_BITS-1:CTRL_BITS]
                              : {PULSE_BITS{1'b0}};
      if (wr_mask_s) begin
        mask_r <= bus.wr_data[NUM_IRQ-1:0];
      end
    end
  end

  // Sticky pending bits (a coincident edge beats the W1C) and registered irq
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_r <= {NUM_IRQ{1'b0}};
      irq_r     <= 1'b0;
    end else begin
      pending_r <= (pending_r & ~clear_s) | rise_s;
      irq_r     <= |(pending_r & mask_r);
    end
  end

  // Registered read port; sampling pre-edge state gives read-before-write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_r  <= {DATA_REG_BITS{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      rd_valid_r <= bus.rd;
      if (bus.rd) begin
        rd_data_r <= rd_mux_s;
      end
    end
  end

  assign bus.rd_data  = rd_data_r;
  assign bus.rd_valid = rd_valid_r;
  assign ctrl_out     = ctrl_r;
  assign ctrl_pulse   = pulse_r;
  assign irq          = irq_r;

  // Upper write-data bits have no register behind them
  assign unused_s = ^bus.wr_data;

endmodule

// File: tb/tb_reg_irq_control.sv
// Self-checking bench for reg_irq_control: reset, a table of register
// write/readback vectors, hand-written interrupt timing sequences and a
// randomized run compared cycle by cycle against a behavioural model.
module tb_reg_irq_control;
  import reg_irq_pkg::*;

  localparam int DW = 32;
  localparam int CB = 5;
  localparam int PB = 3;
  localparam int SB = 6;
  localparam int NI = 8;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [NI-1:0] irq_src;
  logic [SB-1:0] ext_status;
  logic [CB-1:0] ctrl_out;
  logic [PB-1:0] ctrl_pulse;
  logic          irq;

  reg_irq_control_if #(.DATA_REG_BITS(DW)) bus_if ();

  reg_irq_control #(
    .DATA_REG_BITS (DW),
    .CTRL_BITS     (CB),
    .PULSE_BITS    (PB),
    .STATUS_BITS   (SB),
    .NUM_IRQ       (NI),
    .SYNC_STAGES   (SS)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus_if),
    .irq_src    (irq_src),
    .ext_status (ext_status),
    .ctrl_out   (ctrl_out),
    .ctrl_pulse (ctrl_pulse),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]  waddr;
    logic [31:0] wdata;
    logic [2:0]  exp_pulse;
    logic [1:0]  raddr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Advance past the next rising edge; outputs are stable and inputs may change.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [1:0] a, input logic [31:0] d);
    bus_if.address = a;
    bus_if.wr_data = d;
    bus_if.wr      = 1'b1;
    step();
    bus_if.wr      = 1'b0;
  endtask

  task automatic do_read(input logic [1:0] a, output logic [31:0] d);
    bus_if.address = a;
    bus_if.rd      = 1'b1;
    step();
    bus_if.rd      = 1'b0;
    check("rd_valid", 32'(bus_if.rd_valid), 32'd1);
    d = bus_if.rd_data;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] rdv;
    int          lat;
    // behavioural model state
    logic [31:0] m_pend, m_mask, m_ctrl, m_pulse, m_rd, m_valid, m_irq;
    logic [31:0] clr, rise, n_pend;
    logic [NI-1:0] src_q[$];

    vecs[0] = '{ADDR_CONTROL, 32'hFFFF_FFFF, 3'd7, ADDR_CONTROL, 32'h0000_001F};
    vecs[1] = '{ADDR_CONTROL, 32'h0000_0015, 3'd0, ADDR_CONTROL, 32'h0000_0015};
    vecs[2] = '{ADDR_CONTROL, 32'h0000_00E0, 3'd7, ADDR_CONTROL, 32'h0000_0000};
    vecs[3] = '{ADDR_CONTROL, 32'h0000_000A, 3'd0, ADDR_STATUS,  32'h0000_054A};
    vecs[4] = '{ADDR_STATUS,  32'hFFFF_FFFF, 3'd0, ADDR_CONTROL, 32'h0000_000A};
    vecs[5] = '{ADDR_MASK,    32'hFFFF_FFFF, 3'd0, ADDR_MASK,    32'h0000_00FF};
    vecs[6] = '{ADDR_MASK,    32'h0000_01A5, 3'd0, ADDR_MASK,    32'h0000_00A5};
    vecs[7] = '{ADDR_MASK,    32'h0000_0000, 3'd0, ADDR_MASK,    32'h0000_0000};
    vecs[8] = '{ADDR_PENDING, 32'hFFFF_FFFF, 3'd0, ADDR_PENDING, 32'h0000_0000};

    rst            = 1'b1;
    bus_if.wr      = 1'b0;
    bus_if.rd      = 1'b0;
    bus_if.address = ADDR_PENDING;
    bus_if.wr_data = 32'h0;
    irq_src        = 8'h00;
    ext_status     = 6'h00;
    repeat (3) step();
    check("reset_irq", 32'(irq), 32'd0);
    check("reset_ctrl_out", 32'(ctrl_out), 32'd0);
    check("reset_rd_valid", 32'(bus_if.rd_valid), 32'd0);
    rst = 1'b0;
    step();

    // Reset asserted in the middle of a write aborts the pulse and clears state
    do_write(ADDR_MASK, 32'hFF);
    do_write(ADDR_CONTROL, 32'hFF);
    check("pre_reset_pulse", 32'(ctrl_pulse), 32'd7);
    bus_if.address = ADDR_MASK;
    bus_if.wr_data = 32'h5A;
    bus_if.wr      = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("reset_abort_pulse", 32'(ctrl_pulse), 32'd0);
    check("reset_async_ctrl", 32'(ctrl_out), 32'd0);
    step();
    bus_if.wr = 1'b0;
    rst       = 1'b0;
    step();
    for (int a = 0; a < 4; a++) begin
      do_read(2'(a), rdv);
      check("reset_read", rdv, 32'h0);
    end
    check("post_reset_irq", 32'(irq), 32'd0);
    check("post_reset_ctrl_out", 32'(ctrl_out), 32'd0);

    // Table of write / readback vectors
    ext_status = 6'h2A;
    for (int i = 0; i < 9; i++) begin
      do_write(vecs[i].waddr, vecs[i].wdata);
      check("vec_pulse", 32'(ctrl_pulse), 32'(vecs[i].exp_pulse));
      do_read(vecs[i].raddr, rdv);
      check("vec_readback", rdv, vecs[i].exp_rd);
    end

    // CONTROL write: persistent bits, one-cycle pulse, STATUS readback
    do_write(ADDR_CONTROL, 32'h0000_00FF);
    check("ctrl_out_ff", 32'(ctrl_out), 32'h1F);
    check("ctrl_pulse_on", 32'(ctrl_pulse), 32'd7);
    step();
    check("ctrl_pulse_off", 32'(ctrl_pulse), 32'd0);
    do_read(ADDR_CONTROL, rdv);
    check("read_control", rdv, 32'h1F);
    step();
    check("rd_valid_drop", 32'(bus_if.rd_valid), 32'd0);
    check("rd_data_hold", bus_if.rd_data, 32'h1F);
    do_read(ADDR_STATUS, rdv);
    check("read_status", rdv, 32'h55F);
    // back-to-back pulse writes
    bus_if.address = ADDR_CONTROL;
    bus_if.wr      = 1'b1;
    bus_if.wr_data = 32'h20;
    step();
    check("pulse_b2b_0", 32'(ctrl_pulse), 32'd1);
    bus_if.wr_data = 32'h40;
    step();
    check("pulse_b2b_1", 32'(ctrl_pulse), 32'd2);
    bus_if.wr = 1'b0;
    step();
    check("pulse_b2b_end", 32'(ctrl_pulse), 32'd0);

    // Edge-to-irq latency and single event per held level
    do_write(ADDR_MASK, 32'h01);
    irq_src[0] = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (irq) begin
        lat = k;
        break;
      end
    end
    check("irq_latency", 32'(lat), 32'(SS + 2));
    repeat (8) step();
    do_read(ADDR_PENDING, rdv);
    check("pending_src0", rdv, 32'h01);
    do_write(ADDR_PENDING, 32'h01);
    check("irq_before_clear", 32'(irq), 32'd1);
    step();
    check("irq_after_clear", 32'(irq), 32'd0);
    repeat (8) step();
    do_read(ADDR_PENDING, rdv);
    check("no_second_event", rdv, 32'h00);
    irq_src[0] = 1'b0;
    repeat (SS + 2) step();

    // Pending while masked, then unmask and clear
    do_write(ADDR_MASK, 32'h00);
    irq_src[3] = 1'b1;
    repeat (SS + 4) step();
    check("masked_irq", 32'(irq), 32'd0);
    do_read(ADDR_PENDING, rdv);
    check("pending_src3", rdv, 32'h08);
    do_write(ADDR_MASK, 32'h08);
    check("unmask_same_cycle", 32'(irq), 32'd0);
    step();
    check("unmask_irq", 32'(irq), 32'd1);
    do_write(ADDR_PENDING, 32'h08);
    check("w1c_same_cycle", 32'(irq), 32'd1);
    step();
    check("w1c_irq_drop", 32'(irq), 32'd0);
    irq_src[3] = 1'b0;
    repeat (SS + 2) step();

    // W1C coinciding with a synchronised edge: set wins
    irq_src[1] = 1'b1;
    repeat (SS + 3) step();
    do_read(ADDR_PENDING, rdv);
    check("pending_src1", rdv, 32'h02);
    irq_src[1] = 1'b0;
    repeat (SS + 2) step();
    irq_src[1] = 1'b1;
    repeat (SS) step();
    do_write(ADDR_PENDING, 32'h02);
    step();
    do_read(ADDR_PENDING, rdv);
    check("set_wins", rdv, 32'h02);
    do_write(ADDR_PENDING, 32'h02);
    irq_src[1] = 1'b0;
    repeat (SS + 2) step();

    // Simultaneous read and write of MASK returns the old value
    do_write(ADDR_MASK, 32'h08);
    bus_if.address = ADDR_MASK;
    bus_if.wr_data = 32'h5A;
    bus_if.wr      = 1'b1;
    bus_if.rd      = 1'b1;
    step();
    bus_if.wr = 1'b0;
    bus_if.rd = 1'b0;
    check("rw_same_valid", 32'(bus_if.rd_valid), 32'd1);
    check("rw_same_old", bus_if.rd_data, 32'h08);
    do_read(ADDR_MASK, rdv);
    check("rw_same_new", rdv, 32'h5A);

    // Randomized run against the behavioural model; source 2 is high
    // across reset so it must show up as a fresh edge afterwards.
    irq_src = 8'h04;
    rst     = 1'b1;
    step();
    step();
    rst     = 1'b0;
    m_pend = 32'h0; m_mask = 32'h0; m_ctrl = 32'h0; m_pulse = 32'h0;
    m_rd = 32'h0; m_valid = 32'h0; m_irq = 32'h0;
    src_q.delete();
    for (int j = 0; j < SS + 1; j++) src_q.push_back(8'h00);

    for (int i = 0; i < 300; i++) begin
      bus_if.wr      = ($urandom_range(0, 9) < 3);
      bus_if.rd      = ($urandom_range(0, 9) < 4);
      bus_if.address = 2'($urandom_range(0, 3));
      bus_if.wr_data = $urandom;
      ext_status     = 6'($urandom);
      if ($urandom_range(0, 7) == 0) irq_src = irq_src ^ (8'b1 << $urandom_range(0, 7));

      // source value seen SS edges ago rising against the one before it
      src_q.push_back(irq_src);
      rise = 32'(src_q[src_q.size() - 1 - SS] & ~src_q[src_q.size() - 2 - SS]);
      void'(src_q.pop_front());

      if (bus_if.rd) begin
        case (bus_if.address)
          2'd0:    m_rd = m_pend;
          2'd1:    m_rd = m_ctrl;
          2'd2:    m_rd = m_mask;
          default: m_rd = (32'(ext_status) << CB) | m_ctrl;
        endcase
      end
      m_valid = 32'(bus_if.rd);
      m_irq   = ((m_pend & m_mask) != 32'h0) ? 32'd1 : 32'd0;
      clr     = (bus_if.wr && bus_if.address == 2'd0) ? (bus_if.wr_data & 32'hFF) : 32'h0;
      n_pend  = (m_pend & ~clr) | rise;
      m_pulse = 32'h0;
      if (bus_if.wr && bus_if.address == 2'd1) begin
        m_ctrl  = bus_if.wr_data % 32;
        m_pulse = (bus_if.wr_data / 32) % 8;
      end
      if (bus_if.wr && bus_if.address == 2'd2) m_mask = bus_if.wr_data & 32'hFF;
      m_pend = n_pend;

      step();
      check("rnd_ctrl_out", 32'(ctrl_out), m_ctrl);
      check("rnd_ctrl_pulse", 32'(ctrl_pulse), m_pulse);
      check("rnd_irq", 32'(irq), m_irq);
      check("rnd_rd_valid", 32'(bus_if.rd_valid), m_valid);
      check("rnd_rd_data", bus_if.rd_data, m_rd);
    end
    bus_if.wr = 1'b0;
    bus_if.rd = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
